uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: UART_transmitter

---
 rtl/uart_transmitter_pkg.sv | 28 ++
 rtl/uart_transmitter_if.sv | 34 +++
 rtl/uart_transmitter_parity_calculator.sv | 21 ++
 rtl/uart_transmitter.sv | 134 +++++++++++++
 tb/tb_uart_transmitter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions for the transmitter and receiver.
// Contents:
//   uart_state_e   - frame FSM states (IDLE, START, DATA, PARITY, STOP)
//   START_BIT/STOP_BIT - line levels of the framing bits
//   EVEN/ODD       - encodings of the parity_type input
//   eff_prescale() - maps a prescale of 0 to 1 cycle per bit
package uart_transmitter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  // A prescale of zero would give a zero-length bit, so it is run as one cycle.
  function automatic logic [5:0] eff_prescale(input logic [5:0] p);
    return (p == 6'd0) ? 6'd1 : p;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Transmitter request/line interface.
// Signals:
//   parallel_data - word to send, LSB first
//   data_valid    - send request
//   parity_enable - insert a parity bit between data and stop
//   parity_type   - EVEN (0) or ODD (1)
//   prescale      - clk cycles per serial bit (0 runs as 1)
//   serial_data   - UART line, 1 when idle
//   busy          - 1 from the first start-bit cycle through the last stop-bit cycle
// Handshake: a request is taken on a rising clk edge where data_valid=1 and
// busy=0; word and configuration are captured on that same edge. While busy=1
// data_valid is ignored and nothing is queued, so a requester that wants a
// frame sent must keep data_valid high until it sees busy rise.
interface uart_transmitter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] parallel_data;
  logic                  data_valid;
  logic                  parity_enable;
  logic                  parity_type;
  logic [5:0]            prescale;
  logic                  serial_data;
  logic                  busy;

  modport master (
    output parallel_data, data_valid, parity_enable, parity_type, prescale,
    input  serial_data, busy
  );

  modport slave (
    input  parallel_data, data_valid, parity_enable, parity_type, prescale,
    output serial_data, busy
  );
endinterface

// File: rtl/uart_transmitter_parity_calculator.sv
// parity_calculator: parity bit for a data word, shared by transmitter and
// receiver.
// Ports:
//   data        - word to protect
//   parity_type - EVEN (0): bit = XOR of data; ODD (1): bit = XNOR of data
//   parity_bit  - resulting parity bit
module parity_calculator
  import uart_transmitter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             parity_type,
  output logic             parity_bit
);

  always_comb begin
    parity_bit = (parity_type == ODD) ? ~(^data) : ^data;
  end

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises one word per request into a UART frame
// (start 0, data LSB first, optional parity, stop 1), each bit held for
// prescale clk cycles.
// Ports:
//   clk     - clock, all logic on the rising edge
//   reset   - synchronous, active-low
//   tx      - request/line interface (slave side)
//   state_o - current FSM state, for observation
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  uart_transmitter_if.slave   tx,
  output uart_state_e         state_o
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [5:0]            presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  serial_q, serial_d;
  logic                  busy_q, busy_d;
  logic                  parity_bit;
  logic                  bit_done;

  // Parity always comes from the captured word, never the live input.
  parity_calculator #(.WIDTH(DATA_WIDTH)) u_parity (
    .data        (data_q),
    .parity_type (par_type_q),
    .parity_bit  (parity_bit)
  );

  // Counter runs prescale-1 .. 0 inside each bit; 0 marks the bit boundary.
  assign bit_done = (cnt_q == 6'd0);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      presc_q    <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      serial_q   <= STOP_BIT;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      serial_q   <= serial_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    presc_d    = presc_q;
    idx_d      = idx_q;
    data_d     = data_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;

    if (state_q == IDLE) begin
      if (tx.data_valid) begin
        state_d    = START;
        data_d     = tx.parallel_data;
        shift_d    = tx.parallel_data;
        par_en_d   = tx.parity_enable;
        par_type_d = tx.parity_type;
        presc_d    = eff_prescale(tx.prescale);
        cnt_d      = eff_prescale(tx.prescale) - 6'd1;
        idx_d      = '0;
      end
    end else if (!bit_done) begin
      cnt_d = cnt_q - 6'd1;
    end else begin
      cnt_d = presc_q - 6'd1;
      case (state_q)
        START:   state_d = DATA;
        DATA: begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: line level and busy for the state being entered, so both
  // leave the flops aligned with the state register.
  always_comb begin
    serial_d = STOP_BIT;
    busy_d   = (state_d != IDLE);
    case (state_d)
      START:   serial_d = START_BIT;
      DATA:    serial_d = shift_d[0];
      PARITY:  serial_d = parity_bit;
      default: serial_d = STOP_BIT;
    endcase
  end

  assign tx.serial_data = serial_q;
  assign tx.busy        = busy_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
module tb_uart_transmitter;
  import uart_transmitter_pkg::*;

  localparam int DW    = 8;
  localparam int EXP_W = 26; // {prescale[25:20], nbits[19:16], line[15:0]}

  logic        clk;
  logic        reset;
  uart_state_e state_o;

  uart_transmitter_if #(.DATA_WIDTH(DW)) bus ();

  uart_transmitter #(.DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .tx      (bus.slave),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #2.5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [EXP_W-1:0] exp_q[$];
  bit skip_frame = 1'b0;

  // ---------------- reference model ----------------
  // Line levels of a whole frame, bit by bit, from the frame definition.
  function automatic logic [EXP_W-1:0] model_frame(input logic [DW-1:0] d,
      input logic pen, input logic ptype, input logic [5:0] p);
    logic [15:0] line;
    int n;
    logic par;
    line = '1;
    line[0] = 1'b0;
    for (int i = 0; i < DW; i++) line[1+i] = d[i];
    n = DW + 1;
    if (pen) begin
      // Even: total count of ones incl. parity is even; odd: it is odd.
      if (($countones(d) % 2) == 1) par = (ptype == 1'b0);
      else                          par = (ptype == 1'b1);
      line[n] = par;
      n = n + 1;
    end
    line[n] = 1'b1;
    n = n + 1;
    return {((p == 6'd0) ? 6'd1 : p), 4'(n), line};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_busy(input logic v, input int budget, input string nm);
    int n = 0;
    while (bus.busy !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.busy !== v) begin
      $display("FAIL %s: busy=%b required=%b after %0d cycles", nm, bus.busy, v, n);
      bad++;
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic pen, input logic ptype,
                      input logic [5:0] p, input bit push, input bit garble);
    @(negedge clk);
    wait_busy(1'b0, 1000, "idle_before_send");
    if (push) exp_q.push_back(model_frame(d, pen, ptype, p));
    bus.parallel_data = d;
    bus.parity_enable = pen;
    bus.parity_type   = ptype;
    bus.prescale      = p;
    bus.data_valid    = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b1 || bus.serial_data !== 1'b0) begin
      $display("FAIL latency: busy=%b serial=%b required busy=1 serial=0",
               bus.busy, bus.serial_data);
      bad++;
    end
    bus.data_valid = 1'b0;
    if (garble) begin
      // Mid-frame noise on every input, including an ignored request.
      @(negedge clk);
      bus.parallel_data = DW'($urandom);
      bus.parity_enable = 1'($urandom);
      bus.parity_type   = 1'($urandom);
      bus.prescale      = 6'($urandom);
      bus.data_valid    = 1'b1;
      @(negedge clk);
      bus.data_valid    = 1'b0;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic prev_busy;
    logic [EXP_W-1:0] e;
    int p, n, k2;
    bit ok;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1 && prev_busy !== 1'b1) begin
        if (skip_frame) begin
          k2 = 0;
          while (bus.busy === 1'b1 && k2 < 2000) begin
            @(negedge clk);
            k2++;
          end
          skip_frame = 1'b0;
        end else if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: busy=1 with no request outstanding");
          k2 = 0;
          while (bus.busy === 1'b1 && k2 < 2000) begin
            @(negedge clk);
            k2++;
          end
        end else begin
          e = exp_q.pop_front();
          p = int'(e[25:20]);
          n = int'(e[19:16]);
          for (int k = 0; k < n; k++) begin
            ok = 1'b1;
            for (int c = 0; c < p; c++) begin
              if (k != 0 || c != 0) @(negedge clk);
              if (bus.serial_data !== e[k] || bus.busy !== 1'b1) ok = 1'b0;
            end
            total++;
            if (!ok) begin
              bad++;
              $display("FAIL frame_bit%0d: serial=%b busy=%b required serial=%b busy=1 for %0d cycles",
                       k, bus.serial_data, bus.busy, e[k], p);
            end
          end
          @(negedge clk);
          total++;
          if (bus.busy !== 1'b0 || bus.serial_data !== 1'b1) begin
            bad++;
            $display("FAIL frame_end: busy=%b serial=%b required busy=0 serial=1",
                     bus.busy, bus.serial_data);
          end
        end
      end
      prev_busy = bus.busy;
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int g;
    bus.parallel_data = '0;
    bus.data_valid    = 1'b0;
    bus.parity_enable = 1'b0;
    bus.parity_type   = 1'b0;
    bus.prescale      = 6'd8;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.serial_data !== 1'b1 || bus.busy !== 1'b0 || state_o !== IDLE) begin
      bad++;
      $display("FAIL reset_state: serial=%b busy=%b state=%0d required 1/0/IDLE",
               bus.serial_data, bus.busy, state_o);
    end
    reset = 1'b1;

    // Directed frames at prescale 8
    send(8'h6A, 1'b1, EVEN, 6'd8, 1'b1, 1'b0);
    send(8'hA5, 1'b0, EVEN, 6'd8, 1'b1, 1'b0);
    send(8'hF7, 1'b1, ODD,  6'd8, 1'b1, 1'b0);

    // Request while busy is dropped and config changes do not leak in
    send(8'h57, 1'b1, EVEN, 6'd8, 1'b1, 1'b0);
    repeat (29) @(negedge clk);
    bus.parallel_data = 8'h11;
    bus.parity_type   = ODD;
    bus.data_valid    = 1'b1;
    @(negedge clk);
    bus.data_valid    = 1'b0;
    wait_busy(1'b0, 200, "ignored_req_end");
    repeat (20) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL no_second_frame: busy=%b required 0", bus.busy);
    end

    // Reset during the 4th data bit aborts the frame
    skip_frame = 1'b1;
    send(8'h96, 1'b0, EVEN, 6'd8, 1'b0, 1'b0);
    repeat (34) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    total++;
    if (bus.serial_data !== 1'b1 || bus.busy !== 1'b0 || state_o !== IDLE) begin
      bad++;
      $display("FAIL reset_abort: serial=%b busy=%b state=%0d required 1/0/IDLE",
               bus.serial_data, bus.busy, state_o);
    end
    send(8'h55, 1'b0, EVEN, 6'd8, 1'b1, 1'b0);

    // Held data_valid: three back-to-back frames, one idle cycle apart
    @(negedge clk);
    wait_busy(1'b0, 200, "idle_before_hold");
    for (int f = 0; f < 3; f++) exp_q.push_back(model_frame(8'h3C, 1'b1, ODD, 6'd4));
    bus.parallel_data = 8'h3C;
    bus.parity_enable = 1'b1;
    bus.parity_type   = ODD;
    bus.prescale      = 6'd4;
    bus.data_valid    = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_busy(1'b1, 200, "hold_start");
      if (f == 2) bus.data_valid = 1'b0;
      wait_busy(1'b0, 200, "hold_end");
      if (f < 2) begin
        g = 0;
        while (bus.busy !== 1'b1 && g < 10) begin
          @(negedge clk);
          g++;
        end
        total++;
        if (g != 1) begin
          bad++;
          $display("FAIL hold_gap: idle cycles=%0d required 1", g);
        end
      end
    end

    // Randomised frames with mid-frame input noise
    for (int r = 0; r < 12; r++) begin
      send(DW'($urandom), 1'($urandom), 1'($urandom), 6'($urandom_range(0, 6)),
           1'b1, bit'(r % 2));
    end

    @(negedge clk);
    wait_busy(1'b0, 1000, "final_idle");
    repeat (10) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drained: %0d frames outstanding, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case something wedges outside the bounded waits
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
